// File: rtl/conv_mac_multich.sv
// Multi-channel K-tap convolution MAC: 3-stage product/sum/accumulate pipeline
// with per-output channel accumulation. Define CONV_SIGNED_EN for two's complement operands.
module conv_mac_multich #(
  parameter int DATA_W = 8,
  parameter int KTAPS  = 9,
  parameter int MAX_CH = 16,
  parameter int ACC_W  = 2*DATA_W + $clog2(KTAPS) + $clog2(MAX_CH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic                    in_last,
  input  logic [KTAPS*DATA_W-1:0] ifm,
  input  logic                    weight_valid,
  input  logic [KTAPS*DATA_W-1:0] weight,
  output logic                    out_valid,
  output logic [ACC_W-1:0]        out_ofm,
  output logic                    ovf_err,
  output logic                    busy
);

  localparam int PROD_W = 2*DATA_W;
  localparam int CNT_W  = $clog2(MAX_CH);
  localparam int VEC_W  = KTAPS*DATA_W;

  typedef enum logic [0:0] {IDLE, ACCUM} state_t;

  // Operand widening to product width; the product is then taken modulo 2^PROD_W,
  // which is exact for both unsigned and two's complement operands.
  function automatic logic [PROD_W-1:0] ext_op(input logic [DATA_W-1:0] v);
`ifdef CONV_SIGNED_EN
    ext_op = {{DATA_W{v[DATA_W-1]}}, v};
`else
    ext_op = {{DATA_W{1'b0}}, v};
`endif
  endfunction

  function automatic logic [ACC_W-1:0] ext_prod(input logic [PROD_W-1:0] v);
`ifdef CONV_SIGNED_EN
    ext_prod = {{(ACC_W-PROD_W){v[PROD_W-1]}}, v};
`else
    ext_prod = {{(ACC_W-PROD_W){1'b0}}, v};
`endif
  endfunction

  logic [VEC_W-1:0]  w_reg;
  logic [VEC_W-1:0]  w_eff;
  logic [CNT_W-1:0]  ch_cnt;
  logic              cnt_full;
  logic              beat_last;
  logic              beat_err;
  logic [PROD_W-1:0] prod_c [KTAPS];

  logic              p_valid, p_last, p_err;
  logic [PROD_W-1:0] p_prod [KTAPS];

  logic [ACC_W-1:0]  sum_c;
  logic              s_valid, s_last, s_err;
  logic [ACC_W-1:0]  s_sum;

  state_t            state_q, state_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic              emit;

  // A beat that fills the last channel slot is forced to close the output.
  always_comb begin
    w_eff     = weight_valid ? weight : w_reg;
    cnt_full  = (ch_cnt == CNT_W'(MAX_CH-1));
    beat_last = in_last || cnt_full;
    beat_err  = !in_last && cnt_full;
    for (int k = 0; k < KTAPS; k++) begin
      prod_c[k] = ext_op(ifm[k*DATA_W +: DATA_W]) * ext_op(w_eff[k*DATA_W +: DATA_W]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      w_reg   <= '0;
      ch_cnt  <= '0;
      p_valid <= 1'b0;
      p_last  <= 1'b0;
      p_err   <= 1'b0;
      for (int k = 0; k < KTAPS; k++) p_prod[k] <= '0;
    end else begin
      if (weight_valid) w_reg <= weight;
      p_valid <= in_valid;
      p_last  <= in_valid && beat_last;
      p_err   <= in_valid && beat_err;
      if (in_valid) begin
        p_prod <= prod_c;
        ch_cnt <= beat_last ? '0 : ch_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    sum_c = '0;
    for (int k = 0; k < KTAPS; k++) sum_c = sum_c + ext_prod(p_prod[k]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s_valid <= 1'b0;
      s_last  <= 1'b0;
      s_err   <= 1'b0;
      s_sum   <= '0;
    end else begin
      s_valid <= p_valid;
      s_last  <= p_last;
      s_err   <= p_err;
      if (p_valid) s_sum <= sum_c;
    end
  end

  // IDLE means the next beat starts a fresh output, so the accumulator loads.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    emit    = 1'b0;
    if (s_valid) begin
      case (state_q)
        IDLE:    acc_d = s_sum;
        ACCUM:   acc_d = acc_q + s_sum;
        default: acc_d = s_sum;
      endcase
      if (s_last) begin
        state_d = IDLE;
        emit    = 1'b1;
      end else begin
        state_d = ACCUM;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      out_valid <= 1'b0;
      out_ofm   <= '0;
      ovf_err   <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      out_valid <= emit;
      ovf_err   <= emit && s_err;
      if (emit) out_ofm <= acc_d;
    end
  end

  assign busy = p_valid || s_valid || (state_q == ACCUM);

endmodule

// File: tb/tb_conv_mac_multich.sv
// Directed self-checking bench for conv_mac_multich at default parameters;
// signed expectations apply when CONV_SIGNED_EN is defined.
module tb_conv_mac_multich;

  localparam int DATA_W = 8;
  localparam int KTAPS  = 9;
  localparam int MAX_CH = 16;
  localparam int ACC_W  = 24;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    in_valid;
  logic                    in_last;
  logic [KTAPS*DATA_W-1:0] ifm;
  logic                    weight_valid;
  logic [KTAPS*DATA_W-1:0] weight;
  logic                    out_valid;
  logic [ACC_W-1:0]        out_ofm;
  logic                    ovf_err;
  logic                    busy;

  int checks   = 0;
  int failures = 0;
  int pulse_cnt = 0;
  int base;
  logic [31:0] ofm_log [256];
  logic        err_log [256];

  conv_mac_multich #(
    .DATA_W(DATA_W), .KTAPS(KTAPS), .MAX_CH(MAX_CH), .ACC_W(ACC_W)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_last(in_last), .ifm(ifm),
    .weight_valid(weight_valid), .weight(weight), .out_valid(out_valid),
    .out_ofm(out_ofm), .ovf_err(ovf_err), .busy(busy)
  );

  always #5 clk = ~clk;

  // Logs every emitted result shortly after the edge that produced it.
  always @(posedge clk) begin
    #1;
    if (out_valid) begin
      if (pulse_cnt < 256) begin
        ofm_log[pulse_cnt] = 32'(out_ofm);
        err_log[pulse_cnt] = ovf_err;
      end
      pulse_cnt = pulse_cnt + 1;
    end
  end

  task automatic applyStimulus(input logic v, input logic last, input logic [7:0] ib,
                               input logic wv, input logic [7:0] wb);
    @(negedge clk);
    in_valid     = v;
    in_last      = last;
    ifm          = {KTAPS{ib}};
    weight_valid = wv;
    weight       = {KTAPS{wb}};
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 8'd0, 1'b0, 8'd0);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; ifm = '0;
    weight_valid = 1'b0; weight = '0;
    idle(2);
    checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset_out_ofm",   32'(out_ofm),   32'd0);
    checkOutput("reset_ovf_err",   32'(ovf_err),   32'd0);
    checkOutput("reset_busy",      32'(busy),      32'd0);
    rst = 1'b0;
    idle(1);

    // Weight register resets to zero: a beat without a weight load yields 0.
    base = pulse_cnt;
    applyStimulus(1'b1, 1'b1, 8'd5, 1'b0, 8'd0);
    idle(4);
    checkOutput("wreset_pulses", 32'(pulse_cnt), 32'(base + 1));
    checkOutput("wreset_ofm",    ofm_log[base],  32'd0);

    // Single channel of ones, exact latency.
    base = pulse_cnt;
    applyStimulus(1'b1, 1'b1, 8'd1, 1'b1, 8'd1);
    idle(1);
    checkOutput("lat_n1_valid", 32'(out_valid), 32'd0);
    checkOutput("lat_n1_busy",  32'(busy),      32'd1);
    idle(1);
    checkOutput("lat_n2_valid", 32'(out_valid), 32'd0);
    idle(1);
    checkOutput("lat_n3_valid", 32'(out_valid), 32'd1);
    checkOutput("lat_n3_ofm",   32'(out_ofm),   32'd9);
    checkOutput("lat_n3_err",   32'(ovf_err),   32'd0);
    idle(1);
    checkOutput("lat_n4_valid", 32'(out_valid), 32'd0);
    checkOutput("hold_ofm",     32'(out_ofm),   32'd9);
    checkOutput("idle_busy",    32'(busy),      32'd0);

    // Sixteen full-scale channels back to back.
    base = pulse_cnt;
    for (int i = 0; i < 16; i++)
      applyStimulus(1'b1, (i == 15), 8'd255, (i == 0), 8'd255);
    idle(5);
    checkOutput("ch16_pulses", 32'(pulse_cnt), 32'(base + 1));
`ifdef CONV_SIGNED_EN
    checkOutput("ch16_ofm", ofm_log[base], 32'd144);
`else
    checkOutput("ch16_ofm", ofm_log[base], 32'd9363600);
`endif
    checkOutput("ch16_err", 32'(err_log[base]), 32'd0);

    // Seventeen beats with no in_last on the first sixteen.
    base = pulse_cnt;
    for (int i = 0; i < 17; i++)
      applyStimulus(1'b1, (i == 16), 8'd1, (i == 0), 8'd1);
    idle(5);
    checkOutput("ovf_pulses",     32'(pulse_cnt),       32'(base + 2));
    checkOutput("ovf_first_ofm",  ofm_log[base],        32'd144);
    checkOutput("ovf_first_err",  32'(err_log[base]),   32'd1);
    checkOutput("ovf_second_ofm", ofm_log[base+1],      32'd9);
    checkOutput("ovf_second_err", 32'(err_log[base+1]), 32'd0);

    // Weight bypass on the first beat, then a gap before the last beat.
    base = pulse_cnt;
    applyStimulus(1'b1, 1'b0, 8'd1, 1'b1, 8'd2);
    applyStimulus(1'b0, 1'b1, 8'd0, 1'b0, 8'd0);
    idle(2);
    checkOutput("gap_busy", 32'(busy), 32'd1);
    applyStimulus(1'b1, 1'b1, 8'd1, 1'b0, 8'd0);
    idle(5);
    checkOutput("gap_pulses", 32'(pulse_cnt), 32'(base + 1));
    checkOutput("gap_ofm",    ofm_log[base],  32'd36);

    // Back-to-back single-channel outputs must not add to the previous sum.
    base = pulse_cnt;
    applyStimulus(1'b1, 1'b1, 8'd1, 1'b1, 8'd1);
    applyStimulus(1'b1, 1'b1, 8'd2, 1'b0, 8'd0);
    applyStimulus(1'b1, 1'b1, 8'd3, 1'b0, 8'd0);
    idle(5);
    checkOutput("b2b_pulses", 32'(pulse_cnt), 32'(base + 3));
    checkOutput("b2b_ofm0",   ofm_log[base],   32'd9);
    checkOutput("b2b_ofm1",   ofm_log[base+1], 32'd18);
    checkOutput("b2b_ofm2",   ofm_log[base+2], 32'd27);

`ifdef CONV_SIGNED_EN
    base = pulse_cnt;
    applyStimulus(1'b1, 1'b1, 8'h80, 1'b1, 8'h80);
    applyStimulus(1'b1, 1'b1, 8'h80, 1'b1, 8'h7F);
    idle(5);
    checkOutput("sgn_pulses",  32'(pulse_cnt), 32'(base + 2));
    checkOutput("sgn_pos_ofm", ofm_log[base],   32'd147456);
    checkOutput("sgn_neg_ofm", ofm_log[base+1], 32'h00FDC480);
`endif

    // Reset in the middle of a five-channel accumulation.
    base = pulse_cnt;
    applyStimulus(1'b1, 1'b0, 8'd1, 1'b1, 8'd1);
    applyStimulus(1'b1, 1'b0, 8'd1, 1'b0, 8'd0);
    applyStimulus(1'b1, 1'b0, 8'd1, 1'b0, 8'd0);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    checkOutput("rst_busy",      32'(busy),      32'd0);
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_out_ofm",   32'(out_ofm),   32'd0);
    idle(5);
    checkOutput("rst_no_pulse", 32'(pulse_cnt), 32'(base));
    applyStimulus(1'b1, 1'b1, 8'd1, 1'b1, 8'd1);
    idle(5);
    checkOutput("rst_fresh_pulses", 32'(pulse_cnt), 32'(base + 1));
    checkOutput("rst_fresh_ofm",    ofm_log[base],  32'd9);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
